// File: rtl/mult32s_share_arbiter.sv
// Round-robin arbiter sharing one external pipelined 32x32 signed multiplier
// between NREQ requesters; optional counters under MULT32S_SHARE_ARBITER_STATS_EN.
module mult32s_share_arbiter #(
    parameter int NREQ     = 4,
    parameter int IDW      = 2,
    parameter int MULT_LAT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [32*NREQ-1:0]   req_a,
    input  logic [32*NREQ-1:0]   req_b,
    output logic [31:0]          mult_a,
    output logic [31:0]          mult_b,
    input  logic [63:0]          mult_p,
    output logic                 resp_valid,
    output logic [IDW-1:0]       resp_id,
    output logic [63:0]          resp_product,
    output logic                 busy
`ifdef MULT32S_SHARE_ARBITER_STATS_EN
    ,
    input  logic                 stat_clr,
    output logic [31:0]          stat_issued,
    output logic [31:0]          stat_conflict
`endif
);

    logic [IDW-1:0]               ptr_q, ptr_d;
    logic [NREQ-1:0]              grant;
    logic [IDW-1:0]               gnt_id;
    logic                         hs;
    logic                         found;
    logic [31:0]                  scan_sum;
    logic [IDW-1:0]               scan_idx;
    logic [31:0]                  sel_a, sel_b;
    logic [31:0]                  mult_a_q, mult_a_d, mult_b_q, mult_b_d;
    logic [MULT_LAT:0]            tag_v_q, tag_v_d;
    logic [MULT_LAT:0][IDW-1:0]   tag_id_q, tag_id_d;
    logic                         resp_valid_q, resp_valid_d;
    logic [IDW-1:0]               resp_id_q, resp_id_d;
    logic [63:0]                  resp_product_q, resp_product_d;

    // Scan from the pointer upward; the first valid requester wins. Grants are
    // suppressed during reset so req_ready reads zero while rst is held.
    always_comb begin
        grant    = '0;
        gnt_id   = '0;
        found    = 1'b0;
        scan_sum = '0;
        scan_idx = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            scan_sum = 32'(ptr_q) + k;
            scan_idx = IDW'(scan_sum % NREQ);
            if (!found && en && !rst && req_valid[scan_idx]) begin
                grant[scan_idx] = 1'b1;
                gnt_id          = scan_idx;
                found           = 1'b1;
            end
        end
        hs = found;
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int unsigned j = 0; j < NREQ; j++) begin
            if (grant[j]) begin
                sel_a = req_a[32*j +: 32];
                sel_b = req_b[32*j +: 32];
            end
        end
    end

    always_comb begin
        ptr_d    = ptr_q;
        mult_a_d = mult_a_q;
        mult_b_d = mult_b_q;
        if (hs) begin
            ptr_d    = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
            mult_a_d = sel_a;
            mult_b_d = sel_b;
        end
    end

    // Tag stage k lines up with the product MULT_LAT cycles after operand issue.
    always_comb begin
        tag_v_d     = '0;
        tag_id_d    = '0;
        tag_v_d[0]  = hs;
        tag_id_d[0] = gnt_id;
        for (int unsigned k = 1; k <= MULT_LAT; k++) begin
            tag_v_d[k]  = tag_v_q[k-1];
            tag_id_d[k] = tag_id_q[k-1];
        end
    end

    always_comb begin
        resp_valid_d   = tag_v_q[MULT_LAT];
        resp_id_d      = resp_id_q;
        resp_product_d = resp_product_q;
        if (tag_v_q[MULT_LAT]) begin
            resp_id_d      = tag_id_q[MULT_LAT];
            resp_product_d = mult_p;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q          <= '0;
            mult_a_q       <= '0;
            mult_b_q       <= '0;
            tag_v_q        <= '0;
            tag_id_q       <= '0;
            resp_valid_q   <= 1'b0;
            resp_id_q      <= '0;
            resp_product_q <= '0;
        end else begin
            ptr_q          <= ptr_d;
            mult_a_q       <= mult_a_d;
            mult_b_q       <= mult_b_d;
            tag_v_q        <= tag_v_d;
            tag_id_q       <= tag_id_d;
            resp_valid_q   <= resp_valid_d;
            resp_id_q      <= resp_id_d;
            resp_product_q <= resp_product_d;
        end
    end

    assign req_ready    = grant;
    assign mult_a       = mult_a_q;
    assign mult_b       = mult_b_q;
    assign resp_valid   = resp_valid_q;
    assign resp_id      = resp_id_q;
    assign resp_product = resp_product_q;
    assign busy         = (|tag_v_q) | hs;

`ifdef MULT32S_SHARE_ARBITER_STATS_EN
    logic [31:0] stat_issued_q, stat_issued_d;
    logic [31:0] stat_conflict_q, stat_conflict_d;

    always_comb begin
        stat_issued_d   = stat_issued_q;
        stat_conflict_d = stat_conflict_q;
        if (stat_clr) begin
            stat_issued_d   = '0;
            stat_conflict_d = '0;
        end else begin
            if (hs) stat_issued_d = stat_issued_q + 32'd1;
            if (en && ($countones(req_valid) > 1)) stat_conflict_d = stat_conflict_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_issued_q   <= '0;
            stat_conflict_q <= '0;
        end else begin
            stat_issued_q   <= stat_issued_d;
            stat_conflict_q <= stat_conflict_d;
        end
    end

    assign stat_issued   = stat_issued_q;
    assign stat_conflict = stat_conflict_q;
`endif

endmodule

// File: tb/tb_mult32s_share_arbiter.sv
// Directed + random bench for mult32s_share_arbiter against a queue-based reference model.
module tb_mult32s_share_arbiter;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int LAT  = 2;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                en = 1'b0;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ-1:0]     req_ready;
    logic [32*NREQ-1:0]  req_a = '0;
    logic [32*NREQ-1:0]  req_b = '0;
    logic [31:0]         mult_a, mult_b;
    logic [63:0]         mult_p;
    logic                resp_valid;
    logic [IDW-1:0]      resp_id;
    logic [63:0]         resp_product;
    logic                busy;

    mult32s_share_arbiter #(.NREQ(NREQ), .IDW(IDW), .MULT_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .en(en),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .mult_a(mult_a), .mult_b(mult_b), .mult_p(mult_p),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_product(resp_product),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // External multiplier: two-stage pipeline from operands to product.
    logic [63:0] mp1 = '0, mp2 = '0;
    always @(posedge clk) begin
        mp1 <= 64'(longint'($signed(mult_a)) * longint'($signed(mult_b)));
        mp2 <= mp1;
    end
    assign mult_p = mp2;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          id;
        logic [63:0] prod;
        int          due;
    } exp_t;

    exp_t        q[$];
    int          mptr = 0;
    logic [31:0] ra[NREQ];
    logic [31:0] rb[NREQ];
    logic [63:0] last_id = '0;
    logic [63:0] last_prod = '0;
    logic [31:0] ma_exp = '0;
    logic [31:0] mb_exp = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic rand_ops();
        for (int i = 0; i < NREQ; i++) begin
            ra[i] = $urandom;
            rb[i] = $urandom;
        end
    endtask

    task automatic step(input logic [NREQ-1:0] v, input logic e);
        int              g;
        int              idx;
        logic [NREQ-1:0] exp_rdy;
        logic            ev;
        logic            busy_e;
        req_valid = v;
        en        = e;
        for (int i = 0; i < NREQ; i++) begin
            req_a[32*i +: 32] = ra[i];
            req_b[32*i +: 32] = rb[i];
        end
        @(negedge clk);
        g = -1;
        if (e) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (mptr + k) % NREQ;
                if (g < 0 && ((v >> idx) & NREQ'(1)) != '0) g = idx;
            end
        end
        exp_rdy = (g >= 0) ? (NREQ'(1) << g) : '0;
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        chk("mult_a", 64'(mult_a), 64'(ma_exp));
        chk("mult_b", 64'(mult_b), 64'(mb_exp));
        ev = (q.size() > 0) && (q[0].due == cyc);
        if (ev) begin
            last_id   = 64'(q[0].id);
            last_prod = q[0].prod;
            void'(q.pop_front());
        end
        chk("resp_valid", 64'(resp_valid), 64'(ev));
        chk("resp_id", 64'(resp_id), last_id);
        chk("resp_product", resp_product, last_prod);
        busy_e = (g >= 0) || (q.size() > 0);
        chk("busy", 64'(busy), 64'(busy_e));
        if (g >= 0) begin
            q.push_back('{id: g,
                          prod: 64'(longint'($signed(ra[g])) * longint'($signed(rb[g]))),
                          due: cyc + LAT + 2});
            ma_exp = ra[g];
            mb_exp = rb[g];
            mptr   = (g + 1) % NREQ;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_valid = '0;
        en        = 1'b0;
        rst       = 1'b1;
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        chk("rst_resp_valid", 64'(resp_valid), 64'(0));
        chk("rst_resp_id", 64'(resp_id), 64'(0));
        chk("rst_resp_product", resp_product, 64'(0));
        chk("rst_mult_a", 64'(mult_a), 64'(0));
        chk("rst_mult_b", 64'(mult_b), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        q.delete();
        mptr      = 0;
        last_id   = '0;
        last_prod = '0;
        ma_exp    = '0;
        mb_exp    = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rand_ops();
        #2;
        do_reset();

        // single request: 7 * -3
        ra[0] = 32'd7;
        rb[0] = 32'hFFFF_FFFD;
        step(4'b0001, 1'b1);
        for (int i = 0; i < 6; i++) step(4'b0000, 1'b1);

        // all four valid for eight cycles
        for (int i = 0; i < 8; i++) begin
            rand_ops();
            step(4'b1111, 1'b1);
        end
        for (int i = 0; i < 6; i++) step(4'b0000, 1'b1);

        // pointer to 2 via requester 1, then only 1 and 3 contend
        rand_ops();
        step(4'b0010, 1'b1);
        for (int i = 0; i < 3; i++) begin
            rand_ops();
            step(4'b1010, 1'b1);
        end
        for (int i = 0; i < 6; i++) step(4'b0000, 1'b1);

        // en low with one op in flight, then re-enabled
        rand_ops();
        step(4'b0001, 1'b1);
        step(4'b0100, 1'b0);
        step(4'b0100, 1'b1);
        for (int i = 0; i < 6; i++) step(4'b0000, 1'b1);

        // reset one cycle after two issues discards both
        rand_ops();
        step(4'b0011, 1'b1);
        step(4'b0011, 1'b1);
        step(4'b0000, 1'b1);
        do_reset();
        for (int i = 0; i < 6; i++) step(4'b0000, 1'b1);
        rand_ops();
        step(4'b1010, 1'b1);
        for (int i = 0; i < 6; i++) step(4'b0000, 1'b1);

        // operand extremes
        ra[0] = 32'h8000_0000;
        rb[0] = 32'h8000_0000;
        step(4'b0001, 1'b1);
        ra[0] = 32'hFFFF_FFFF;
        rb[0] = 32'h0000_0001;
        step(4'b0001, 1'b1);
        for (int i = 0; i < 6; i++) step(4'b0000, 1'b1);

        // random traffic with occasional en drops
        for (int i = 0; i < 300; i++) begin
            rand_ops();
            step(NREQ'($urandom), ($urandom_range(0, 7) != 0));
        end
        for (int i = 0; i < 8; i++) step(4'b0000, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
